// File: rtl/alu_issue_pkg.sv
// Shared constants, encodings, FSM states and the instruction decoder for alu_issue.
package alu_issue_pkg;

    // RV32 major opcodes handled by this block
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Operation codes understood by the downstream ALU ({instr[30], funct3})
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_e;

    typedef struct packed {
        logic       fault;
        logic       use_imm;
        logic [3:0] op;
    } decode_t;

    // Classify an instruction word and pick the ALU operation and B-bus source.
    function automatic decode_t decode_instr(input logic [31:0] instr, input int num_regs);
        decode_t    d;
        logic [6:0] funct7;
        logic [2:0] funct3;
        funct7    = instr[31:25];
        funct3    = instr[14:12];
        d.fault   = 1'b0;
        d.use_imm = 1'b0;
        d.op      = ALU_ADD;
        case (instr[6:0])
            OPC_OP: begin
                d.op = {instr[30], funct3};
                if (funct7 != F7_BASE && funct7 != F7_ALT)
                    d.fault = 1'b1;
                if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
                    d.fault = 1'b1;
                if (int'(instr[24:20]) >= num_regs)
                    d.fault = 1'b1;
            end
            OPC_OP_IMM: begin
                d.use_imm = 1'b1;
                if (funct3 == 3'b101) begin
                    // Only shifts take instr[30]; ADDI with imm bit 10 set stays ADD
                    d.op = instr[30] ? ALU_SRA : ALU_SRL;
                    if (funct7 != F7_BASE && funct7 != F7_ALT)
                        d.fault = 1'b1;
                end else begin
                    d.op = {1'b0, funct3};
                    if (funct3 == 3'b001 && funct7 != F7_BASE)
                        d.fault = 1'b1;
                end
            end
            default: d.fault = 1'b1;
        endcase
        if (int'(instr[11:7]) >= num_regs || int'(instr[19:15]) >= num_regs)
            d.fault = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two registered read ports, one write port, one combinational debug port.
module alu_issue_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Write port; x0 and out-of-range addresses are discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the whole array is cleared on reset because software relies on all registers reading 0; this costs a reset net on every bit.
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0 && int'(wr_addr) < NUM_REGS) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Registered read ports; values hold until the next enabled read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            rs1_data <= '0;
            rs2_data <= '0;
        end else if (rd_en) begin
            rs1_data <= (rs1_addr != 5'd0 && int'(rs1_addr) < NUM_REGS) ? mem[rs1_addr[AW-1:0]] : '0;
            rs2_data <= (rs2_addr != 5'd0 && int'(rs2_addr) < NUM_REGS) ? mem[rs2_addr[AW-1:0]] : '0;
        end
    end

    // Combinational debug read; x0 and unimplemented registers read as 0
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != 5'd0 && int'(dbg_addr) < NUM_REGS)
            dbg_data = mem[dbg_addr[AW-1:0]];
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes one OP/OP-IMM instruction, reads operands, drives the ALU and writes back.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_fault,
    output logic                  done,
    output logic                  fault,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    state_e                state, state_next;
    decode_t               dec;
    logic                  rf_re, rf_we;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

    // Fields captured at accept
    logic [4:0]            rd_q, rs1_q, rs2_q;
    logic [11:0]           imm_q;
    logic                  fault_q;
    logic                  use_imm_q;
    logic [3:0]            op_q;

    // B-bus source captured on entry to EXEC, held afterwards
    logic                  b_imm_sel;
    logic [DATA_WIDTH-1:0] b_imm;

    assign dec = decode_instr(instr, NUM_REGS);

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake/retire outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
        state_next  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        rf_re       = 1'b0;
        rf_we       = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = dec.fault ? WB : READ;
            end
            READ: begin
                rf_re      = 1'b1;
                state_next = EXEC;
            end
            EXEC: state_next = WB;
            WB: begin
                done       = 1'b1;
                fault      = fault_q | alu_fault;
                rf_we      = !fault_q && !alu_fault && (rd_q != 5'd0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted instruction's fields and decode result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            fault_q   <= 1'b0;
            use_imm_q <= 1'b0;
            op_q      <= '0;
        end else if (state == IDLE && instr_valid) begin
            rd_q      <= instr[11:7];
            rs1_q     <= instr[19:15];
            rs2_q     <= instr[24:20];
            imm_q     <= instr[31:20];
            fault_q   <= dec.fault;
            use_imm_q <= dec.use_imm;
            op_q      <= dec.op;
        end
    end

    // ALU op and B-bus source update on the READ->EXEC edge, alongside the operand reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op    <= '0;
            b_imm_sel <= 1'b0;
            b_imm     <= '0;
        end else if (state == READ) begin
            alu_op    <= OP_WIDTH'(op_q);
            b_imm_sel <= use_imm_q;
            b_imm     <= {{(DATA_WIDTH-12){imm_q[11]}}, imm_q};
        end
    end

    assign alu_a = rs1_val;
    assign alu_b = b_imm_sel ? b_imm : rs2_val;

    alu_issue_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rf_re),
        .rs1_addr (rs1_q),
        .rs2_addr (rs2_q),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (rf_we),
        .wr_addr  (rd_q),
        .wr_data  (alu_out),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases, randomized instructions, reset during EXEC.
module tb_alu_issue;
    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_fault;
    logic        done, fault;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int          tests = 0;
    int          failures = 0;
    logic [31:0] model_regs [32];
    bit          inj = 1'b0;

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_fault   (alu_fault),
        .done        (done),
        .fault       (fault),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Downstream ALU stand-in: result and fault registered one clock after its inputs
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return {1'b0, a + b};
            4'b1000: return {1'b0, a - b};
            4'b0001: return {1'b0, a << b[4:0]};
            4'b0010: return {1'b0, 31'd0, $signed(a) < $signed(b)};
            4'b0011: return {1'b0, 31'd0, a < b};
            4'b0100: return {1'b0, a ^ b};
            4'b0101: return {1'b0, a >> b[4:0]};
            4'b1101: return {1'b0, 32'($signed(a) >>> b[4:0])};
            4'b0110: return {1'b0, a | b};
            4'b0111: return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    always @(posedge clk) begin
        {alu_fault, alu_out} <= alu_model(alu_op, alu_a, alu_b) | {inj, 32'd0};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Reference: legality straight from the RV32E OP/OP-IMM rules
    function automatic bit ref_legal(input logic [31:0] i);
        bit ok;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = i[31:25];
        f3 = i[14:12];
        if (i[6:0] == 7'b0110011)
            ok = (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) && (i[24:20] < NR);
        else if (i[6:0] == 7'b0010011)
            ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else
            ok = 1'b0;
        return ok && (i[11:7] < NR) && (i[19:15] < NR);
    endfunction

    function automatic logic [3:0] ref_op(input logic [31:0] i);
        if (i[6:0] == 7'b0110011 || i[14:12] == 3'd5)
            return {i[30], i[14:12]};
        return {1'b0, i[14:12]};
    endfunction

    // Reference: architectural result of the instruction
    function automatic logic [31:0] ref_result(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        case (i[14:12])
            3'd0: return (i[6:0] == 7'b0110011 && i[30]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return i[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Offer one instruction, follow it to retirement and check bus values, latency, fault and rd
    task automatic issue(input logic [31:0] word, input bit inject, input string tag);
        bit          legal;
        logic [31:0] a_val, b_val, res;
        logic [3:0]  op_before;
        logic [4:0]  rd;
        int          lat;
        int          w;
        legal     = ref_legal(word);
        rd        = word[11:7];
        a_val     = model_regs[word[19:15]];
        b_val     = (word[6:0] == 7'b0110011) ? model_regs[word[24:20]] : {{20{word[31]}}, word[31:20]};
        res       = ref_result(word, a_val, b_val);
        op_before = alu_op;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, 32'(instr_ready), 32'd1);
        inj         = inject;
        instr       = word;
        instr_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0;
                check({tag, " busy"}, 32'(instr_ready), 32'd0);
            end
            if (c == 2 && legal) begin
                check({tag, " exec op"}, 32'(alu_op), 32'(ref_op(word)));
                check({tag, " exec a"}, alu_a, a_val);
                check({tag, " exec b"}, alu_b, b_val);
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, legal ? 32'd3 : 32'd1);
        check({tag, " fault"}, 32'(fault), 32'(!legal || inject));
        check({tag, " op held"}, 32'(alu_op), legal ? 32'(ref_op(word)) : 32'(op_before));
        inj = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        if (legal && !inject && rd != 5'd0)
            model_regs[rd] = res;
        dbg_addr = rd;
        #1;
        check({tag, " rd"}, dbg_data, model_regs[rd]);
    endtask

    task automatic check_all_regs(input string tag);
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            check($sformatf("%s x%0d", tag, r), dbg_data, (r < NR) ? model_regs[r] : 32'd0);
        end
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        dbg_addr = r;
        #1;
        v = dbg_data;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] word;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        int          kind;

        for (int r = 0; r < 32; r++)
            model_regs[r] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset instr_ready", 32'(instr_ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check_all_regs("reset");

        // Dependent ADDI/ADD pair
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 1'b0, "addi x1");
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b0, "add x2");
        read_reg(5'd1, v); check("x1 literal", v, 32'd5);
        read_reg(5'd2, v); check("x2 literal", v, 32'd10);

        // Arithmetic vs logical right shift of all-ones
        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd3), 1'b0, "addi x3");
        issue(enc_i({7'h20, 5'd4}, 5'd3, 3'd5, 5'd4), 1'b0, "srai x4");
        issue(enc_i({7'h00, 5'd4}, 5'd3, 3'd5, 5'd5), 1'b0, "srli x5");
        read_reg(5'd4, v); check("x4 literal", v, 32'hFFFF_FFFF);
        read_reg(5'd5, v); check("x5 literal", v, 32'h0FFF_FFFF);

        // ADDI whose immediate sets instr[30] must stay an ADD
        issue(enc_i(12'h400, 5'd0, 3'd0, 5'd6), 1'b0, "addi x6 0x400");
        check("addi 0x400 alu_op", 32'(alu_op), 32'd0);
        read_reg(5'd6, v); check("x6 literal", v, 32'h0000_0400);

        // Illegal encodings: bad funct7, non-ALU opcode
        issue(32'h0200_0033, 1'b0, "bad funct7");
        issue(32'h0000_2083, 1'b0, "load opcode");
        check_all_regs("after illegal");

        // Destination beyond RV32E register count, then ALU-reported fault
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd16), 1'b0, "add x16");
        read_reg(5'd16, v); check("x16 reads 0", v, 32'd0);
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd8), 1'b1, "add x8 alu_fault");
        read_reg(5'd8, v); check("x8 untouched", v, 32'd0);

        // Randomized mix of OP, OP-IMM and foreign opcodes
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            rd   = 5'($urandom_range(0, 17));
            rs1  = 5'($urandom_range(0, 17));
            rs2  = 5'($urandom_range(0, 17));
            f3   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1, 2: f7 = 7'h00;
                3, 4:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            if (kind < 4)
                word = enc_r(f7, rs2, rs1, f3, rd);
            else if (kind < 9)
                word = (f3 == 3'd1 || f3 == 3'd5) ? enc_i({f7, rs2}, rs1, f3, rd)
                                                  : enc_i(12'($urandom), rs1, f3, rd);
            else
                word = {$urandom} & 32'hFFFF_FF80 | 32'h0000_0003;
            issue(word, $urandom_range(0, 7) == 0, $sformatf("rand%0d", n));
        end
        check_all_regs("after random");

        // Reset while ADDI x7,x0,9 is in EXEC
        instr       = enc_i(12'd9, 5'd0, 3'd0, 5'd7);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("rst exec alu_b", alu_b, 32'd9);
        #2 reset = 1'b1;
        #1;
        check("rst async alu_op", 32'(alu_op), 32'd0);
        check("rst async alu_b", alu_b, 32'd0);
        check("rst async done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst held done", 32'(done), 32'd0);
        reset = 1'b0;
        #1;
        check("rst release ready", 32'(instr_ready), 32'd1);
        for (int r = 0; r < 32; r++)
            model_regs[r] = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst no done %0d", c), 32'(done), 32'd0);
        end
        read_reg(5'd7, v); check("x7 zero", v, 32'd0);
        check_all_regs("after reset");

        // Recovery after reset
        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd7), 1'b0, "addi x7 again");
        read_reg(5'd7, v); check("x7 literal", v, 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and register width.
REQ-002 Parameter NUM_REGS, default 16, architectural register count (RV32E); legal values 16 or 32.
REQ-003 Parameter OP_WIDTH, default 4, ALU op code width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instr_valid  in  1  instruction word offered.
REQ-007 instr_ready  out  1  block can accept an instruction.
REQ-008 instr  in  32  RV32 instruction, opcode 0010011 (OP-IMM) or 0110011 (OP).
REQ-009 alu_op  out  OP_WIDTH  operation to the downstream ALU.
REQ-010 alu_a  out  DATA_WIDTH  ALU bus A (rs1 value).
REQ-011 alu_b  out  DATA_WIDTH  ALU bus B (rs2 value or immediate).
REQ-012 alu_out  in  DATA_WIDTH  ALU result, registered by the ALU one clk after its inputs.
REQ-013 alu_fault  in  1  ALU invalid-operation flag, same timing as alu_out.
REQ-014 done  out  1  one-cycle pulse: instruction retired.
REQ-015 fault  out  1  valid with done: instruction illegal, no register written.
REQ-016 dbg_addr  in  5  debug read address; dbg_data  out  DATA_WIDTH  combinational register read (0 for x0 or address >= NUM_REGS).

Function
REQ-017 FSM states IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on instr_valid && instr_ready, latch instr and decode; legal -> READ, illegal -> WB with fault latched.
REQ-019 READ: register rs1 (instr[19:15]) and rs2 (instr[24:20]) values; -> EXEC.
REQ-020 EXEC: drive alu_op/alu_a/alu_b (held stable through this cycle); -> WB.
REQ-021 WB: done=1 one cycle; on legal path sample alu_out/alu_fault; fault = decode fault | alu_fault; write alu_out to rd (instr[11:7]) iff !fault and rd != 0; -> IDLE.
REQ-022 Latency accept-edge to done: 3 clk legal, 1 clk illegal; throughput one instruction per 4 clk.
REQ-023 OP: alu_op = {instr[30], funct3}; alu_b = rs2 value.
REQ-024 OP-IMM: alu_op = {instr[30], 101} when funct3=101, else {0, funct3} (ADDI with instr[30]=1 SHALL NOT become SUB); alu_b = sign-extended instr[31:20].
REQ-025 Decode fault: opcode other than 0010011/0110011; OP with funct7 not 0000000/0100000; OP with funct7=0100000 and funct3 not 000/101; OP-IMM funct3=001 with funct7 != 0000000; OP-IMM funct3=101 with funct7 not 0000000/0100000; rd, rs1 or rs2 (OP only) >= NUM_REGS.
REQ-026 x0 reads SHALL return 0; writes to x0 SHALL be discarded.
REQ-027 Source equal to rd of the previous instruction SHALL read the written value (write completes in WB before next READ).
REQ-028 alu_op/alu_a/alu_b SHALL hold last values outside EXEC.

Reset
REQ-029 reset asserted at any time SHALL force IDLE immediately, abandoning any in-flight instruction without register write.
REQ-030 Reset values: instr_ready=1 after reset release (0 while reset held not required), done=0, fault=0, alu_op=0, alu_a=0, alu_b=0, all registers 0.

Structure
REQ-031 Shared package SHALL hold opcode constants (OP_IMM, OP), funct7 constants, ALU op encodings (ADD 0000 ... SRA 1101) and the FSM state enum.
REQ-032 Register file SHALL be one sub-module regfile (NUM_REGS x DATA_WIDTH, two registered read ports, one write port, one combinational debug port).

Verification
REQ-033 ADDI x1,x0,5 then ADD x2,x1,x1 -> dbg x1=5, x2=10, done 3 clk after each accept, fault=0.
REQ-034 ADDI x3,x0,-1 then SRAI x4,x3,4 and SRLI x5,x3,4 -> x4=0xFFFFFFFF, x5=0x0FFFFFFF.
REQ-035 ADDI with instr[30]=1 (imm 0x400) on x0 -> x6=0x400, alu_op=0000 during EXEC.
REQ-036 instr=0x00000033 with funct7=0000001 or opcode 0000011 -> done+fault 1 clk after accept, alu_op never changes, no register changed.
REQ-037 ADD x16,x1,x1 with NUM_REGS=16 -> fault=1, dbg_addr=16 reads 0; ALU returning alu_fault=1 on a legal ADD -> fault=1, rd unchanged.
REQ-038 reset asserted during EXEC of ADDI x7,x0,9 -> FSM IDLE asynchronously, no done pulse, x7=0.
